pipe_hazard_unit: RTL and testbench

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/sat_counter.sv | 26 ++
 rtl/pipe_hazard_unit.sv | 162 ++++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings for the pipeline hazard unit.
//   - one-hot status codes (AOK/HLT/ADR/INS)
//   - instruction codes the hazard logic cares about
//   - hazard-unit FSM state type
package pipe_pkg;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk   - clock
//   rst_n - asynchronous active-low reset (q -> 0)
//   clr   - synchronous clear, wins over inc
//   inc   - count enable; q sticks at all-ones
//   q     - count value
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: pipeline stall/bubble control, exception drain FSM and
// performance counters.
//   Inputs : D_icode, d_srcA, d_srcB (decode), E_icode, E_dstM, e_cnd (execute),
//            M_icode, m_stat, m_ready (memory), W_stat (writeback), cnt_clr.
//   Outputs: F_stall, D_stall, D_bubble, E_bubble, M_stall, M_bubble, W_stall,
//            set_cc, halted, stall_cnt, bubble_cnt, mispred_cnt.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int               REG_W = 4,
  parameter int               CNT_W = 16,
  parameter logic [REG_W-1:0] RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [REG_W-1:0] d_srcA,
  input  logic [REG_W-1:0] d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [REG_W-1:0] E_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       M_icode,
  input  logic [0:3]       m_stat,
  input  logic             m_ready,
  input  logic [0:3]       W_stat,
  input  logic             cnt_clr,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_stall,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  state_t state, state_nxt;

  logic mem_wait, mispred, load_use, ret_any;
  logic mispred_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    mem_wait = ((M_icode == ICODE_MRMOVQ) || (M_icode == ICODE_POPQ) ||
                (M_icode == ICODE_RET)) && !m_ready;
    mispred  = (E_icode == ICODE_JXX) && !e_cnd;
    load_use = ((E_icode == ICODE_MRMOVQ) || (E_icode == ICODE_POPQ)) &&
               (E_dstM != RNONE) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret_any  = (D_icode == ICODE_RET) || (E_icode == ICODE_RET) ||
               (M_icode == ICODE_RET);
  end

  always_comb begin
    state_nxt   = state;
    F_stall     = 1'b0;
    D_stall     = 1'b0;
    D_bubble    = 1'b0;
    E_bubble    = 1'b0;
    M_stall     = 1'b0;
    M_bubble    = 1'b0;
    W_stall     = 1'b0;
    set_cc      = 1'b1;
    halted      = 1'b0;
    mispred_hit = 1'b0;

    unique case (state)
      ST_RUN: begin
        if (m_stat != STAT_AOK)
          state_nxt = ST_DRAIN;
        if (mem_wait) begin
          F_stall = 1'b1;
          D_stall = 1'b1;
          M_stall = 1'b1;
        end else if (mispred) begin
          D_bubble    = 1'b1;
          E_bubble    = 1'b1;
          mispred_hit = 1'b1;
        end else if (load_use) begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          E_bubble = 1'b1;
        end else if (ret_any) begin
          F_stall  = 1'b1;
          D_bubble = 1'b1;
        end
        if ((E_icode == ICODE_HALT) || (m_stat != STAT_AOK) || (W_stat != STAT_AOK))
          set_cc = 1'b0;
      end
      ST_DRAIN: begin
        if (W_stat != STAT_AOK)
          state_nxt = ST_HALTED;
        set_cc   = 1'b0;
        M_bubble = 1'b1;
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
      end
      ST_HALTED: begin
        set_cc   = 1'b0;
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
        halted   = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase

    // Outputs are forced quiet while reset is held, independent of the clock.
    if (!rst_n) begin
      F_stall     = 1'b0;
      D_stall     = 1'b0;
      D_bubble    = 1'b0;
      E_bubble    = 1'b0;
      M_stall     = 1'b0;
      M_bubble    = 1'b0;
      W_stall     = 1'b0;
      set_cc      = 1'b0;
      halted      = 1'b0;
      mispred_hit = 1'b0;
    end
  end

  logic in_run;
  assign in_run = (state == ST_RUN);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (in_run && F_stall),
    .q     (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (in_run && (E_bubble || D_bubble)),
    .q     (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (in_run && mispred_hit),
    .q     (mispred_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed vectors for pipe_hazard_unit. A second
// instance with 4-bit counters shares all inputs to exercise saturation.
module tb_pipe_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  D_icode, E_icode, M_icode;
  logic [3:0]  d_srcA, d_srcB, E_dstM;
  logic        e_cnd, m_ready, cnt_clr;
  logic [0:3]  m_stat, W_stat;

  logic F_stall, D_stall, D_bubble, E_bubble, M_stall, M_bubble, W_stall, set_cc, halted;
  logic [15:0] stall_cnt, bubble_cnt, mispred_cnt;

  logic s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_stall, s_M_bubble, s_W_stall;
  logic s_set_cc, s_halted;
  logic [3:0] s_stall_cnt, s_bubble_cnt, s_mispred_cnt;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .M_icode(M_icode),
    .m_stat(m_stat), .m_ready(m_ready), .W_stat(W_stat), .cnt_clr(cnt_clr),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_stall(M_stall), .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
    .halted(halted), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .mispred_cnt(mispred_cnt)
  );

  pipe_hazard_unit #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .M_icode(M_icode),
    .m_stat(m_stat), .m_ready(m_ready), .W_stat(W_stat), .cnt_clr(cnt_clr),
    .F_stall(s_F_stall), .D_stall(s_D_stall), .D_bubble(s_D_bubble), .E_bubble(s_E_bubble),
    .M_stall(s_M_stall), .M_bubble(s_M_bubble), .W_stall(s_W_stall), .set_cc(s_set_cc),
    .halted(s_halted), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt),
    .mispred_cnt(s_mispred_cnt)
  );

  // {F_stall, D_stall, D_bubble, E_bubble, M_stall, M_bubble, W_stall, set_cc, halted}
  logic [8:0] ctl;
  assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_stall, M_bubble, W_stall, set_cc, halted};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after a rising edge; sampling happens 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = 4'h0; d_srcB = 4'h1; E_dstM = 4'hF;
    e_cnd = 1'b1; m_ready = 1'b1; cnt_clr = 1'b0;
    m_stat = 4'b1000; W_stat = 4'b1000;
  endtask

  task automatic load_use_in();
    idle();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    check("reset_ctl", 32'(ctl), 32'h000);
    check("reset_cnt", {stall_cnt, bubble_cnt}, 32'h0);
    check("reset_mis", 32'(mispred_cnt), 32'h0);

    @(negedge clk); rst_n = 1'b1;
    tick(); #1;
    check("idle_ctl", 32'(ctl), 32'b000000010);

    // load-use
    load_use_in(); #1;
    check("lu_ctl", 32'(ctl), 32'b110100010);
    tick();
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    check("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);

    // RNONE destination is never a hazard
    idle(); E_icode = 4'hB; E_dstM = 4'hF; d_srcB = 4'hF; d_srcA = 4'h2; #1;
    check("rnone_ctl", 32'(ctl), 32'b000000010);
    tick();
    check("rnone_cnt", 32'(stall_cnt), 32'd1);

    // mispredict beats ret
    idle(); E_icode = 4'h7; e_cnd = 1'b0; D_icode = 4'h9; #1;
    check("mis_ctl", 32'(ctl), 32'b001100010);
    tick();
    check("mis_cnt", 32'(mispred_cnt), 32'd1);
    check("mis_bubble_cnt", 32'(bubble_cnt), 32'd2);
    check("mis_stall_cnt", 32'(stall_cnt), 32'd1);

    // taken jump: no mispredict
    idle(); E_icode = 4'h7; e_cnd = 1'b1; #1;
    check("jtaken_ctl", 32'(ctl), 32'b000000010);
    tick();

    // ret in memory stage, memory ready
    idle(); M_icode = 4'h9; #1;
    check("ret_ctl", 32'(ctl), 32'b101000010);
    tick();
    check("ret_stall_cnt", 32'(stall_cnt), 32'd2);
    check("ret_bubble_cnt", 32'(bubble_cnt), 32'd3);

    // memory wait for 3 cycles, load-use also present
    for (int i = 0; i < 3; i++) begin
      load_use_in(); M_icode = 4'h5; m_ready = 1'b0; #1;
      check($sformatf("mw_ctl%0d", i), 32'(ctl), 32'b110010010);
      tick();
    end
    check("mw_stall_cnt", 32'(stall_cnt), 32'd5);
    check("mw_bubble_cnt", 32'(bubble_cnt), 32'd3);

    // halt in execute blocks cc write
    idle(); E_icode = 4'h0; #1;
    check("halt_e_ctl", 32'(ctl), 32'b000000000);
    tick();

    // exception path
    idle(); m_stat = 4'b0010; #1;
    check("exc_run_ctl", 32'(ctl), 32'b000000000);
    tick();
    idle(); #1;
    check("drain_ctl", 32'(ctl), 32'b110101000);
    tick();
    check("drain_no_cnt", 32'(stall_cnt), 32'd5);
    W_stat = 4'b0010;
    tick();
    W_stat = 4'b1000; #1;
    check("halted_ctl", 32'(ctl), 32'b110101101);
    tick(); tick();
    check("halted_hold", 32'(ctl), 32'b110101101);
    check("halted_no_cnt", 32'(stall_cnt), 32'd5);

    // reset pulse, mid-cycle
    @(negedge clk); #2; rst_n = 1'b0; #1;
    check("rst2_ctl", 32'(ctl), 32'h000);
    check("rst2_cnt", {stall_cnt, bubble_cnt}, 32'h0);
    check("rst2_mis", 32'(mispred_cnt), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rst2_run_ctl", 32'(ctl), 32'b000000010);
    tick();
    check("rst2_run_cnt", 32'(stall_cnt), 32'd0);

    // saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      load_use_in();
      tick();
    end
    check("sat_small", 32'(s_stall_cnt), 32'd15);
    check("sat_big", 32'(stall_cnt), 32'd20);
    load_use_in(); cnt_clr = 1'b1;
    tick();
    check("clr_small", 32'(s_stall_cnt), 32'd0);
    check("clr_big", 32'(stall_cnt), 32'd0);
    check("clr_bubble", 32'(bubble_cnt), 32'd0);
    cnt_clr = 1'b0;
    tick();
    check("post_clr", 32'(s_stall_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
